stopwatch_ctrl: RTL and testbench

Stopwatch controller that sequences the seconds-tick datapath: a prescaler producing a one-cycle tick every TICK_COUNT cycles, and a two-digit BCD counter (00–99). A four-state FSM driven by three pushbuttons controls start/stop, lap freeze and clear. A time-multiplexed digit scanner feeds one BCD nibble per slot to the shared seg7 decoder, with a one-hot digit select.

---
 rtl/stopwatch_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch: button edge detect, run/pause/lap/clear FSM,
// tick prescaler, 00-99 counter with lap capture, and a two-slot digit scanner.
module stopwatch_ctrl #(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
    parameter logic [15:0] SCAN_COUNT = 16'd10_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_btn_start_stop,
    input  logic       i_btn_lap,
    input  logic       i_btn_clear,
    output logic [3:0] o_digit_out,
    output logic [1:0] o_digit_sel,
    output logic [7:0] o_count_bcd,
    output logic       o_running,
    output logic       o_lap_active,
    output logic       o_tick_out
);

    // state    | meaning
    // S_IDLE   | cleared, waiting for start
    // S_RUN    | counting, live count displayed
    // S_PAUSED | counting frozen, partial tick period retained
    // S_LAP    | counting, captured lap value displayed
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_LAP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_ss_q;
    logic        r_lap_q;
    logic        r_clr_q;
    logic        w_ss_edge;
    logic        w_lap_edge;
    logic        w_clr_edge;

    logic        w_running;
    logic        w_lap_mode;
    logic        w_lap_capture;
    logic        w_clear;

    logic [23:0] r_presc;
    logic        w_tick_term;
    logic [3:0]  r_ones;
    logic [3:0]  r_tens;
    logic [7:0]  r_lap;
    logic        r_tick;

    logic [15:0] r_scan;
    logic [1:0]  r_sel;
    logic [7:0]  w_disp;

    // Previous levels load during reset too, so a held button never edges on release.
    always_ff @(posedge clk) begin
        r_ss_q  <= i_btn_start_stop;
        r_lap_q <= i_btn_lap;
        r_clr_q <= i_btn_clear;
    end

    assign w_ss_edge  = i_btn_start_stop & ~r_ss_q;
    assign w_lap_edge = i_btn_lap & ~r_lap_q;
    assign w_clr_edge = i_btn_clear & ~r_clr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_running     = 1'b0;
        w_lap_mode    = 1'b0;
        w_lap_capture = 1'b0;
        w_clear       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ss_edge) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_running = 1'b1;
                if (w_ss_edge) begin
                    w_state_nxt = S_PAUSED;
                end else if (w_lap_edge) begin
                    w_state_nxt   = S_LAP;
                    w_lap_capture = 1'b1;
                end
            end
            S_LAP: begin
                w_running  = 1'b1;
                w_lap_mode = 1'b1;
                if (w_ss_edge) begin
                    w_state_nxt = S_PAUSED;
                end else if (w_lap_edge) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_PAUSED: begin
                if (w_clr_edge) begin
                    w_state_nxt = S_IDLE;
                    w_clear     = 1'b1;
                end else if (w_ss_edge) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Counting follows the current state, so a pause edge on the terminal cycle still takes the tick.
    assign w_tick_term = w_running && (r_presc == (TICK_COUNT - 24'd1));

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_presc <= 24'd0;
        end else if (w_running) begin
            if (w_tick_term) begin
                r_presc <= 24'd0;
            end else begin
                r_presc <= r_presc + 24'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
        end else if (w_tick_term) begin
            if (r_ones == 4'd9) begin
                r_ones <= 4'd0;
                r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick_term;
        end
    end

    // Captures the registered count, i.e. the value before a coincident tick.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_lap <= 8'h00;
        end else if (w_lap_capture) begin
            r_lap <= {r_tens, r_ones};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan <= 16'd0;
            r_sel  <= 2'b01;
        end else if (r_scan == (SCAN_COUNT - 16'd1)) begin
            r_scan <= 16'd0;
            r_sel  <= {r_sel[0], r_sel[1]};
        end else begin
            r_scan <= r_scan + 16'd1;
        end
    end

    assign w_disp = w_lap_mode ? r_lap : {r_tens, r_ones};

    assign o_digit_out  = r_sel[1] ? w_disp[7:4] : w_disp[3:0];
    assign o_digit_sel  = r_sel;
    assign o_count_bcd  = {r_tens, r_ones};
    assign o_running    = w_running;
    assign o_lap_active = w_lap_mode;
    assign o_tick_out   = r_tick;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: fixed vector table, directed corner sequences and
// random button traffic, all compared against an elapsed-time reference model.
module tb_stopwatch_ctrl;

    localparam int TICK = 4;
    localparam int SCAN = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] digit_out;
    logic [1:0] digit_sel;
    logic [7:0] count_bcd;
    logic       running;
    logic       lap_active;
    logic       tick_out;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_COUNT(24'd4),
        .SCAN_COUNT(16'd3)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .i_btn_start_stop(btn_ss),
        .i_btn_lap       (btn_lap),
        .i_btn_clear     (btn_clr),
        .o_digit_out     (digit_out),
        .o_digit_sel     (digit_sel),
        .o_count_bcd     (count_bcd),
        .o_running       (running),
        .o_lap_active    (lap_active),
        .o_tick_out      (tick_out)
    );

    // Reference model: time is tracked as total cycles spent counting since the last clear.
    typedef enum {M_IDLE, M_RUN, M_PAUSED, M_LAP} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_elapsed = 0;
    int    m_lapval = 0;
    int    m_scan = 0;
    bit    m_tick = 1'b0;
    bit    m_pss = 1'b0;
    bit    m_plap = 1'b0;
    bit    m_pclr = 1'b0;

    function automatic int m_cnt();
        return (m_elapsed / TICK) % 100;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic logic [1:0] m_sel();
        return (((m_scan / SCAN) % 2) == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_edge(input bit r, input bit s, input bit l, input bit c);
        bit es;
        bit el;
        bit ec;
        int old_cnt;
        es = s && !m_pss;
        el = l && !m_plap;
        ec = c && !m_pclr;
        old_cnt = m_cnt();
        if (r) begin
            m_mode    = M_IDLE;
            m_elapsed = 0;
            m_lapval  = 0;
            m_scan    = 0;
            m_tick    = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (m_mode == M_RUN || m_mode == M_LAP) begin
                m_elapsed++;
                m_tick = ((m_elapsed % TICK) == 0);
            end
            case (m_mode)
                M_IDLE: if (es) m_mode = M_RUN;
                M_RUN: begin
                    if (es) m_mode = M_PAUSED;
                    else if (el) begin
                        m_mode   = M_LAP;
                        m_lapval = old_cnt;
                    end
                end
                M_LAP: begin
                    if (es) m_mode = M_PAUSED;
                    else if (el) m_mode = M_RUN;
                end
                M_PAUSED: begin
                    if (ec) begin
                        m_mode    = M_IDLE;
                        m_elapsed = 0;
                        m_lapval  = 0;
                    end else if (es) m_mode = M_RUN;
                end
                default: m_mode = M_IDLE;
            endcase
            m_scan++;
        end
        m_pss  = s;
        m_plap = l;
        m_pclr = c;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int disp;
        logic [1:0] sel;
        sel  = m_sel();
        disp = (m_mode == M_LAP) ? m_lapval : m_cnt();
        chk("model_count_bcd", 32'(count_bcd), 32'(to_bcd(m_cnt())));
        chk("model_running", 32'(running), 32'(m_mode == M_RUN || m_mode == M_LAP));
        chk("model_lap_active", 32'(lap_active), 32'(m_mode == M_LAP));
        chk("model_tick_out", 32'(tick_out), 32'(m_tick));
        chk("model_digit_sel", 32'(digit_sel), 32'(sel));
        chk("model_digit_out", 32'(digit_out), (sel == 2'b01) ? 32'(disp % 10) : 32'(disp / 10));
    endtask

    task automatic step(input bit r, input bit s, input bit l, input bit c);
        @(negedge clk);
        reset   = r;
        btn_ss  = s;
        btn_lap = l;
        btn_clr = c;
        @(posedge clk);
        model_edge(r, s, l, c);
        #1;
        check_model();
    endtask

    typedef struct {
        bit         r, s, l, c;
        logic [7:0] cnt;
        bit         run, lapa, tick;
        logic [1:0] sel;
        logic [3:0] dig;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [7:0] saved;
        bit         found;
        bit         rs, rl, rc, rr;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b10, 4'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b10, 4'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b10, 4'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b01, 4'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 2'b01, 4'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 2'b01, 4'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 2'b10, 4'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 2'b10, 4'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1, 1'b1, 2'b10, 4'd0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 2'b01, 4'd2};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 4'd0};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].c);
            chk($sformatf("vec%0d_count", i), 32'(count_bcd), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_running", i), 32'(running), 32'(tbl[i].run));
            chk($sformatf("vec%0d_lap_active", i), 32'(lap_active), 32'(tbl[i].lapa));
            chk($sformatf("vec%0d_tick", i), 32'(tick_out), 32'(tbl[i].tick));
            chk($sformatf("vec%0d_sel", i), 32'(digit_sel), 32'(tbl[i].sel));
            chk($sformatf("vec%0d_digit", i), 32'(digit_out), 32'(tbl[i].dig));
        end

        // Long run through the 99 -> 00 wrap.
        step(0, 1, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 0, 0);
        chk("count_after_40", 32'(count_bcd), 32'h10);
        for (int i = 0; i < 359; i++) step(0, 0, 0, 0);
        chk("count_at_399", 32'(count_bcd), 32'h99);
        step(0, 0, 0, 0);
        chk("count_wrap_400", 32'(count_bcd), 32'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        chk("count_after_wrap", 32'(count_bcd), 32'h01);

        // Lap freeze at 05 while counting continues.
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        chk("count_before_lap", 32'(count_bcd), 32'h05);
        step(0, 0, 1, 0);
        chk("lap_enter", 32'(lap_active), 32'd1);
        for (int i = 0; i < 11; i++) begin
            step(0, 0, 0, 0);
            chk("lap_digit", 32'(digit_out), (m_sel() == 2'b01) ? 32'd5 : 32'd0);
        end
        chk("lap_count_live", 32'(count_bcd), 32'h08);
        chk("lap_still_active", 32'(lap_active), 32'd1);
        step(0, 0, 1, 0);
        chk("lap_exit", 32'(lap_active), 32'd0);
        chk("lap_exit_count", 32'(count_bcd), 32'h08);
        chk("lap_exit_digit", 32'(digit_out), (m_sel() == 2'b01) ? 32'd8 : 32'd0);

        // Pause two cycles into a period; resume must keep the partial period.
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(0, 0, 0, 0);
            found = tick_out;
        end
        chk("tick_seen", 32'(found), 32'd1);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        saved = count_bcd;
        chk("paused_running", 32'(running), 32'd0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        chk("paused_count_held", 32'(count_bcd), 32'(to_bcd(m_cnt())));
        chk("paused_count_same", 32'(count_bcd), 32'(saved));
        chk("paused_still", 32'(running), 32'd0);
        step(0, 1, 0, 0);
        chk("resume_running", 32'(running), 32'd1);
        chk("resume_tick0", 32'(tick_out), 32'd0);
        step(0, 0, 0, 0);
        chk("resume_tick1", 32'(tick_out), 32'd0);
        step(0, 0, 0, 0);
        chk("resume_tick2", 32'(tick_out), 32'd1);

        // Clear and start_stop together in PAUSED: clear wins.
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 1);
        chk("clear_prio_count", 32'(count_bcd), 32'h00);
        chk("clear_prio_running", 32'(running), 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("idle_lap_running", 32'(running), 32'd0);
        chk("idle_lap_active", 32'(lap_active), 32'd0);

        // start_stop beats lap in RUN, then reset mid-count with all buttons held.
        step(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        chk("ss_lap_running", 32'(running), 32'd0);
        chk("ss_lap_active", 32'(lap_active), 32'd0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(1, 1, 1, 1);
        chk("rst_count", 32'(count_bcd), 32'h00);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_lap", 32'(lap_active), 32'd0);
        chk("rst_tick", 32'(tick_out), 32'd0);
        chk("rst_sel", 32'(digit_sel), 32'b01);
        chk("rst_digit", 32'(digit_out), 32'd0);
        step(0, 1, 1, 1);
        chk("rst_held_no_edge", 32'(running), 32'd0);
        step(0, 0, 0, 0);

        // Random button traffic with occasional resets.
        rs = 1'b0;
        rl = 1'b0;
        rc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rs = ~rs;
            if ($urandom_range(0, 7) == 0) rl = ~rl;
            if ($urandom_range(0, 9) == 0) rc = ~rc;
            rr = ($urandom_range(0, 299) == 0);
            step(rr, rs, rl, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
